// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the step-clock controller and its button front end.
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN_LO  = 3'd1,
        ST_RUN_HI  = 3'd2,
        ST_STEP_LO = 3'd3,
        ST_STEP_HI = 3'd4,
        ST_HALT    = 3'd5
    } clk_state_t;

    localparam logic CLK_IDLE_LEVEL     = 1'b1;
    localparam logic BTN_RELEASED_LEVEL = 1'b1;

    function automatic logic is_low_phase(input clk_state_t s);
        return (s == ST_RUN_LO) || (s == ST_STEP_LO);
    endfunction

    // States whose duration is governed by the phase timer.
    function automatic logic is_timed_phase(input clk_state_t s);
        return (s == ST_RUN_LO) || (s == ST_RUN_HI) ||
               (s == ST_STEP_LO) || (s == ST_STEP_HI);
    endfunction

endpackage

// File: rtl/clock_step_ctrl_debounce_sync.sv
// Step button front end: 2-flop synchronizer, stability-count debouncer and a
// registered single-cycle press pulse on each accepted release->press change.
module debounce_sync
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic n_btn,
    output logic press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1  <= BTN_RELEASED_LEVEL;
            sync_2  <= BTN_RELEASED_LEVEL;
            level   <= BTN_RELEASED_LEVEL;
            level_d <= BTN_RELEASED_LEVEL;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_1  <= n_btn;
            sync_2  <= sync_1;
            level_d <= level;
            // Only a 1->0 change of the accepted level counts as a press.
            press   <= level_d & ~level;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_2;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/clock_step_ctrl.sv
// Step clock generator: free-run with programmable half period, debounced
// single-step, and CPU halt. N_CP_OUT idles high; the falling edge is active.
module clock_step_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RUN,
    input  logic                 N_STEP_BTN,
    input  logic                 N_HALT,
    input  logic [DIV_WIDTH-1:0] DIV,
    output logic                 N_CP_OUT,
    output logic                 STEP_BUSY,
    output logic                 HALTED
);

    localparam logic [DIV_WIDTH-1:0] PHASE_ONE = DIV_WIDTH'(1);

    clk_state_t           state;
    clk_state_t           state_next;
    logic [DIV_WIDTH-1:0] phase_cnt;
    logic [DIV_WIDTH-1:0] div_lat;
    logic                 phase_end;
    logic                 press;

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (CLK),
        .rst  (RST),
        .n_btn(N_STEP_BTN),
        .press(press)
    );

    assign phase_end = (phase_cnt == div_lat);

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (!N_HALT)    state_next = ST_HALT;
                else if (RUN)   state_next = ST_RUN_LO;
                else if (press) state_next = ST_STEP_LO;
            end
            // A started low phase always runs to completion.
            ST_RUN_LO: begin
                if (phase_end) state_next = ST_RUN_HI;
            end
            ST_RUN_HI: begin
                if (phase_end) begin
                    if (!N_HALT)  state_next = ST_HALT;
                    else if (RUN) state_next = ST_RUN_LO;
                    else          state_next = ST_IDLE;
                end
            end
            ST_STEP_LO: begin
                if (phase_end) state_next = ST_STEP_HI;
            end
            ST_STEP_HI: begin
                if (phase_end) state_next = N_HALT ? ST_IDLE : ST_HALT;
            end
            // RUN must be dropped before leaving halt, so a halted CPU never auto-resumes.
            ST_HALT: begin
                if (N_HALT && !RUN) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            N_CP_OUT  <= CLK_IDLE_LEVEL;
            STEP_BUSY <= 1'b0;
            HALTED    <= 1'b0;
        end else begin
            state     <= state_next;
            N_CP_OUT  <= is_low_phase(state_next) ? ~CLK_IDLE_LEVEL : CLK_IDLE_LEVEL;
            STEP_BUSY <= (state_next == ST_STEP_LO) || (state_next == ST_STEP_HI);
            HALTED    <= (state_next == ST_HALT);
            if (state_next != state) begin
                phase_cnt <= '0;
            end else if (is_timed_phase(state)) begin
                phase_cnt <= phase_cnt + PHASE_ONE;
            end
        end
    end

    // The half-period is frozen for the whole phase; only the entry edge samples DIV.
    always_ff @(posedge CLK) begin
        if (state_next != state && is_timed_phase(state_next)) begin
            div_lat <= DIV;
        end
    end

`ifndef SYNTHESIS
    localparam logic [DIV_WIDTH:0] LEN_ONE = (DIV_WIDTH + 1)'(1);

    logic                 prev_cp;
    logic [DIV_WIDTH:0]   low_len;
    logic [DIV_WIDTH-1:0] low_div;

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_cp <= CLK_IDLE_LEVEL;
            low_len <= '0;
            low_div <= '0;
        end else begin
            prev_cp <= N_CP_OUT;
            if (prev_cp && !N_CP_OUT) begin
                low_len <= LEN_ONE;
                low_div <= div_lat;
            end else if (!N_CP_OUT) begin
                low_len <= low_len + LEN_ONE;
            end
            assert (!(STEP_BUSY && HALTED));
            if (state == ST_IDLE || state == ST_HALT) begin
                assert (N_CP_OUT == CLK_IDLE_LEVEL);
            end
            if (!prev_cp && N_CP_OUT) begin
                assert (low_len == ({1'b0, low_div} + LEN_ONE));
            end
        end
    end
`endif

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Directed bench for clock_step_ctrl (DEBOUNCE_CYCLES=4): per-edge expected outputs are
// queued with the stimulus and checked one entry per clock edge.
module tb_clock_step_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RUN;
    logic       N_STEP_BTN;
    logic       N_HALT;
    logic [7:0] DIV;
    logic       N_CP_OUT;
    logic       STEP_BUSY;
    logic       HALTED;

    typedef struct packed {
        logic cp;
        logic busy;
        logic halted;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    compared   = 0;
    int    mismatched = 0;

    clock_step_ctrl #(
        .DIV_WIDTH      (8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RUN       (RUN),
        .N_STEP_BTN(N_STEP_BTN),
        .N_HALT    (N_HALT),
        .DIV       (DIV),
        .N_CP_OUT  (N_CP_OUT),
        .STEP_BUSY (STEP_BUSY),
        .HALTED    (HALTED)
    );

    always #5 CLK = ~CLK;

    task automatic push(input string tag, input int n, input logic cp, input logic busy,
                        input logic halted);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{cp: cp, busy: busy, halted: halted});
            tag_q.push_back(tag);
        end
    endtask

    task automatic tick_check();
        obs_t  obs;
        obs_t  expv;
        string tag;
        @(posedge CLK);
        #1;
        obs = '{cp: N_CP_OUT, busy: STEP_BUSY, halted: HALTED};
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $error("FAIL scoreboard_empty: observed cp/busy/halted=%b required a queued entry", obs);
        end else begin
            expv = exp_q.pop_front();
            tag  = tag_q.pop_front();
            assert (obs === expv) else begin
                mismatched++;
                $error("FAIL %s: observed cp/busy/halted=%b required %b", tag, obs, expv);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick_check();
    endtask

    initial begin
        RST = 1'b1; RUN = 1'b0; N_HALT = 1'b1; N_STEP_BTN = 1'b1; DIV = 8'd2;

        // Reset for two edges, then idle.
        push("reset", 2, 1'b1, 1'b0, 1'b0);
        run(2);
        RST = 1'b0;
        push("reset_idle", 5, 1'b1, 1'b0, 1'b0);
        run(5);

        // Single step: button low before edge 1, falls at edge 8.
        N_STEP_BTN = 1'b0;
        push("step_wait", 7, 1'b1, 1'b0, 1'b0);
        push("step_lo",   3, 1'b0, 1'b1, 1'b0);
        push("step_hi",   3, 1'b1, 1'b1, 1'b0);
        push("step_idle", 6, 1'b1, 1'b0, 1'b0);
        run(19);
        N_STEP_BTN = 1'b1;
        push("step_release", 10, 1'b1, 1'b0, 1'b0);
        run(10);

        // Bounce: 3-cycle glitches never reach the debounce threshold.
        for (int r = 0; r < 4; r++) begin
            N_STEP_BTN = 1'b0;
            push("bounce_lo", 3, 1'b1, 1'b0, 1'b0);
            run(3);
            N_STEP_BTN = 1'b1;
            push("bounce_hi", 3, 1'b1, 1'b0, 1'b0);
            run(3);
        end
        push("bounce_after", 10, 1'b1, 1'b0, 1'b0);
        run(10);

        // Free run DIV=0: period 2.
        RUN = 1'b1; DIV = 8'd0;
        for (int i = 0; i < 6; i++) begin
            push("run_div0_lo", 1, 1'b0, 1'b0, 1'b0);
            push("run_div0_hi", 1, 1'b1, 1'b0, 1'b0);
        end
        run(12);
        // Drop RUN mid-low with DIV=2: low completes, one full high, then idle.
        DIV = 8'd2;
        push("run_stop_lo", 1, 1'b0, 1'b0, 1'b0);
        run(1);
        RUN = 1'b0;
        push("run_stop_lo",   2, 1'b0, 1'b0, 1'b0);
        push("run_stop_hi",   3, 1'b1, 1'b0, 1'b0);
        push("run_stop_idle", 5, 1'b1, 1'b0, 1'b0);
        run(10);

        // Halt requested mid RUN_LO.
        RUN = 1'b1;
        push("halt_lo", 1, 1'b0, 1'b0, 1'b0);
        run(1);
        N_HALT = 1'b0;
        push("halt_lo",     2, 1'b0, 1'b0, 1'b0);
        push("halt_hi",     3, 1'b1, 1'b0, 1'b0);
        push("halt_entered", 4, 1'b1, 1'b0, 1'b1);
        run(9);
        N_HALT = 1'b1;
        push("halt_run_held", 4, 1'b1, 1'b0, 1'b1);
        run(4);
        RUN = 1'b0;
        push("halt_exit", 4, 1'b1, 1'b0, 1'b0);
        run(4);

        // In idle, halt beats RUN.
        N_HALT = 1'b0; RUN = 1'b1;
        push("idle_halt_prio", 2, 1'b1, 1'b0, 1'b1);
        run(2);
        N_HALT = 1'b1; RUN = 1'b0;
        push("idle_halt_exit", 2, 1'b1, 1'b0, 1'b0);
        run(2);

        // DIV 2->5 mid-phase: current low 3 cycles, following phases 6.
        RUN = 1'b1; DIV = 8'd2;
        push("div_chg_lo3", 1, 1'b0, 1'b0, 1'b0);
        run(1);
        DIV = 8'd5;
        push("div_chg_lo3", 2, 1'b0, 1'b0, 1'b0);
        push("div_chg_hi6", 6, 1'b1, 1'b0, 1'b0);
        push("div_chg_lo6", 1, 1'b0, 1'b0, 1'b0);
        run(9);
        RUN = 1'b0;
        push("div_chg_lo6",  5, 1'b0, 1'b0, 1'b0);
        push("div_chg_hi6",  6, 1'b1, 1'b0, 1'b0);
        push("div_chg_idle", 3, 1'b1, 1'b0, 1'b0);
        run(14);

        // Second press lands during STEP_HI (DIV=5) and must be dropped.
        push("hi_press_wait", 7,  1'b1, 1'b0, 1'b0);
        push("hi_press_lo",   6,  1'b0, 1'b1, 1'b0);
        push("hi_press_hi",   6,  1'b1, 1'b1, 1'b0);
        push("hi_press_idle", 11, 1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 30; e++) begin
            N_STEP_BTN = (e <= 4 || (e >= 9 && e <= 20)) ? 1'b0 : 1'b1;
            tick_check();
        end
        N_STEP_BTN = 1'b1;
        push("hi_press_after", 5, 1'b1, 1'b0, 1'b0);
        run(5);

        // Reset in the middle of STEP_LO.
        DIV = 8'd2;
        N_STEP_BTN = 1'b0;
        push("rst_step_wait", 7, 1'b1, 1'b0, 1'b0);
        push("rst_step_lo",   2, 1'b0, 1'b1, 1'b0);
        run(9);
        RST = 1'b1; N_STEP_BTN = 1'b1;
        push("rst_mid_lo", 1, 1'b1, 1'b0, 1'b0);
        run(1);
        RST = 1'b0;
        push("rst_after", 8, 1'b1, 1'b0, 1'b0);
        run(8);

        compared++;
        assert (exp_q.size() == 0) else begin
            mismatched++;
            $error("FAIL scoreboard_drain: observed %0d entries left required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
